// File: rtl/jtag_tap_param_if.sv
// rtl/jtag_tap_param_if.sv - JTAG serial pin bundle (TMS/TDI in, TDO/TDO_en out)
interface jtag_tap_param_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_en;

  modport master (output TMS, output TDI, input TDO, input TDO_en);
  modport slave  (input TMS, input TDI, output TDO, output TDO_en);
endinterface

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised IEEE 1149.1 TAP with IR, IDCODE, bypass, BSR and USER hook
module jtag_tap_param #(
  parameter int unsigned IR_size      = 4,
  parameter int unsigned BSR_size     = 248,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5003,
  parameter int unsigned OP_EXTEST    = 0,
  parameter int unsigned OP_SAMPLE    = 1,
  parameter int unsigned OP_IDCODE    = 2,
  parameter int unsigned OP_INTEST    = 3,
  parameter int unsigned OP_USER      = 4
) (
  input  logic                TCK,
  input  logic                reset,
  jtag_tap_param_if.slave     jtag,
  output logic [3:0]          tap_state,
  input  logic [BSR_size-1:0] bsr_capture_in,
  output logic [BSR_size-1:0] bsr_update_out,
  output logic                extest_mode,
  output logic                intest_mode,
  output logic                user_select,
  output logic                user_capture,
  output logic                user_shift,
  output logic                user_update,
  input  logic                user_tdo
);

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0, EXIT1_DR   = 4'h1, SHIFT_DR   = 4'h2, PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4, UPDATE_DR  = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8, EXIT1_IR   = 4'h9, SHIFT_IR   = 4'hA, PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC, UPDATE_IR  = 4'hD, CAPTURE_IR = 4'hE, TEST_RESET = 4'hF
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_size-1:0]  ir_shift_q, ir_shift_d;
  logic [IR_size-1:0]  ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_q, idcode_d;
  logic [BSR_size-1:0] bsr_shift_q, bsr_shift_d;
  logic [BSR_size-1:0] bsr_upd_q, bsr_upd_d;
  logic                extest_q, extest_d;
  logic                intest_q, intest_d;
  logic                user_sel_q, user_sel_d;

  logic clear;
  logic sel_user, sel_idcode, sel_bsr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_RESET: state_d = jtag.TMS ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   state_d = jtag.TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  state_d = jtag.TMS ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: state_d = jtag.TMS ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   state_d = jtag.TMS ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   state_d = jtag.TMS ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   state_d = jtag.TMS ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   state_d = jtag.TMS ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  state_d = jtag.TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  state_d = jtag.TMS ? TEST_RESET : CAPTURE_IR;
      CAPTURE_IR: state_d = jtag.TMS ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   state_d = jtag.TMS ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   state_d = jtag.TMS ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   state_d = jtag.TMS ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   state_d = jtag.TMS ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  state_d = jtag.TMS ? SELECT_DR  : RUN_IDLE;
      default:    state_d = TEST_RESET;
    endcase
    if (reset) state_d = TEST_RESET;
  end

  // DR selection; anything not decoded falls through to the bypass bit
  always_comb begin
    sel_user   = (ir_q == IR_size'(OP_USER));
    sel_idcode = !sel_user && (ir_q == IR_size'(OP_IDCODE));
    sel_bsr    = !sel_user && !sel_idcode &&
                 ((ir_q == IR_size'(OP_EXTEST)) || (ir_q == IR_size'(OP_SAMPLE)) ||
                  (ir_q == IR_size'(OP_INTEST)));
  end

  always_comb begin
    clear       = reset || (state_q == TEST_RESET);
    ir_shift_d  = ir_shift_q;
    ir_d        = ir_q;
    bypass_d    = bypass_q;
    idcode_d    = idcode_q;
    bsr_shift_d = bsr_shift_q;
    bsr_upd_d   = bsr_upd_q;
    if (clear) begin
      ir_shift_d  = '0;
      ir_d        = IR_size'(OP_IDCODE);
      bypass_d    = 1'b0;
      idcode_d    = '0;
      bsr_shift_d = '0;
      bsr_upd_d   = '0;
    end else begin
      case (state_q)
        CAPTURE_IR: ir_shift_d = IR_size'(1);
        SHIFT_IR: begin
          ir_shift_d              = ir_shift_q >> 1;
          ir_shift_d[IR_size-1]   = jtag.TDI;
        end
        UPDATE_IR:  ir_d = ir_shift_q;
        CAPTURE_DR: begin
          if (sel_idcode)   idcode_d    = IDCODE_VALUE;
          else if (sel_bsr) bsr_shift_d = bsr_capture_in;
          else if (!sel_user) bypass_d  = 1'b0;
        end
        SHIFT_DR: begin
          if (sel_idcode) begin
            idcode_d = {jtag.TDI, idcode_q[31:1]};
          end else if (sel_bsr) begin
            bsr_shift_d             = bsr_shift_q >> 1;
            bsr_shift_d[BSR_size-1] = jtag.TDI;
          end else if (!sel_user) begin
            bypass_d = jtag.TDI;
          end
        end
        UPDATE_DR: if (sel_bsr) bsr_upd_d = bsr_shift_q;
        default: ;
      endcase
    end
    // Modes follow the latch value being written so they line up with the new decode
    extest_d   = (ir_d == IR_size'(OP_EXTEST));
    intest_d   = (ir_d == IR_size'(OP_INTEST));
    user_sel_d = (ir_d == IR_size'(OP_USER));
  end

  always_ff @(posedge TCK) begin
    state_q     <= state_d;
    ir_shift_q  <= ir_shift_d;
    ir_q        <= ir_d;
    bypass_q    <= bypass_d;
    idcode_q    <= idcode_d;
    bsr_shift_q <= bsr_shift_d;
    bsr_upd_q   <= bsr_upd_d;
    extest_q    <= extest_d;
    intest_q    <= intest_d;
    user_sel_q  <= user_sel_d;
  end

  always_comb begin
    jtag.TDO = 1'b0;
    if (state_q == SHIFT_IR) begin
      jtag.TDO = ir_shift_q[0];
    end else if (state_q == SHIFT_DR) begin
      if (sel_user)        jtag.TDO = user_tdo;
      else if (sel_idcode) jtag.TDO = idcode_q[0];
      else if (sel_bsr)    jtag.TDO = bsr_shift_q[0];
      else                 jtag.TDO = bypass_q;
    end
  end

  assign jtag.TDO_en    = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
  assign tap_state      = state_q;
  assign bsr_update_out = bsr_upd_q;
  assign extest_mode    = extest_q;
  assign intest_mode    = intest_q;
  assign user_select    = user_sel_q;
  assign user_capture   = user_sel_q && (state_q == CAPTURE_DR);
  assign user_shift     = user_sel_q && (state_q == SHIFT_DR);
  assign user_update    = user_sel_q && (state_q == UPDATE_DR);

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - directed vector bench for jtag_tap_param
module tb_jtag_tap_param;
  localparam int BSR = 248;

  logic           TCK = 1'b0;
  logic           reset;
  logic [3:0]     tap_state;
  logic [BSR-1:0] bsr_capture_in;
  logic [BSR-1:0] bsr_update_out;
  logic           extest_mode, intest_mode, user_select;
  logic           user_capture, user_shift, user_update;
  logic           user_tdo;

  jtag_tap_param_if jif ();

  jtag_tap_param dut (
    .TCK(TCK), .reset(reset), .jtag(jif), .tap_state(tap_state),
    .bsr_capture_in(bsr_capture_in), .bsr_update_out(bsr_update_out),
    .extest_mode(extest_mode), .intest_mode(intest_mode), .user_select(user_select),
    .user_capture(user_capture), .user_shift(user_shift), .user_update(user_update),
    .user_tdo(user_tdo)
  );

  always #5 TCK = ~TCK;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;
  int cnt_cap = 0, cnt_shift = 0, cnt_upd = 0;

  always @(negedge TCK) if (mon_en) begin
    cnt_cap   += int'(user_capture);
    cnt_shift += int'(user_shift);
    cnt_upd   += int'(user_update);
  end

  typedef struct {
    string      name;
    logic [7:0] tms_bits;
    int         len;
    logic [3:0] exp_state;
  } path_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    @(negedge TCK);
    jif.TMS = tms;
    jif.TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Runs a full scan from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input bit is_ir, input int n, input logic [255:0] tdi_bits,
                      input logic [255:0] utdo_bits, output logic [255:0] tdo_bits);
    int en_bad;
    en_bad   = 0;
    tdo_bits = '0;
    step(1, 0);
    if (is_ir) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < n; i++) begin
      user_tdo = utdo_bits[i];
      #1;
      tdo_bits[i] = jif.TDO;
      if (jif.TDO_en !== 1'b1) en_bad++;
      step(i == n - 1, tdi_bits[i]);
    end
    user_tdo = 1'b0;
    step(1, 0);
    step(0, 0);
    check(is_ir ? "ir_scan_tdo_en" : "dr_scan_tdo_en", 256'(en_bad), 256'(0));
    check("scan_end_rti", 256'(tap_state), 256'(4'hC));
  endtask

  path_t paths[16];
  logic [255:0] tdo;
  logic [BSR-1:0] cap;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    paths[0]  = '{"tlr",      8'h00, 0, 4'hF};
    paths[1]  = '{"rti",      8'h00, 1, 4'hC};
    paths[2]  = '{"sel_dr",   8'h02, 2, 4'h7};
    paths[3]  = '{"cap_dr",   8'h02, 3, 4'h6};
    paths[4]  = '{"shift_dr", 8'h02, 4, 4'h2};
    paths[5]  = '{"exit1_dr", 8'h0A, 4, 4'h1};
    paths[6]  = '{"pause_dr", 8'h0A, 5, 4'h3};
    paths[7]  = '{"exit2_dr", 8'h2A, 6, 4'h0};
    paths[8]  = '{"upd_dr",   8'h1A, 5, 4'h5};
    paths[9]  = '{"sel_ir",   8'h06, 3, 4'h4};
    paths[10] = '{"cap_ir",   8'h06, 4, 4'hE};
    paths[11] = '{"shift_ir", 8'h06, 5, 4'hA};
    paths[12] = '{"exit1_ir", 8'h16, 5, 4'h9};
    paths[13] = '{"pause_ir", 8'h16, 6, 4'hB};
    paths[14] = '{"exit2_ir", 8'h56, 7, 4'h8};
    paths[15] = '{"upd_ir",   8'h36, 6, 4'hD};

    cap            = {{29{8'hC3}}, 8'h5A, 8'hA5};
    bsr_capture_in = cap;
    user_tdo       = 1'b0;
    jif.TMS        = 1'b1;
    jif.TDI        = 1'b0;
    reset          = 1'b1;
    step(1, 0);
    step(1, 0);
    reset = 1'b0;

    check("reset_state",   256'(tap_state), 256'(4'hF));
    check("reset_bsr_upd", 256'(bsr_update_out), 256'(0));
    check("reset_modes",   256'({extest_mode, intest_mode, user_select}), 256'(0));
    check("reset_strobes", 256'({user_capture, user_shift, user_update}), 256'(0));
    check("reset_tdo",     256'({jif.TDO, jif.TDO_en}), 256'(0));

    step(0, 0);
    scan(0, 32, '0, '0, tdo);
    check("idcode", tdo, 256'(32'h1234_5003));
    check("rti_tdo_en", 256'(jif.TDO_en), 256'(0));

    foreach (paths[p]) begin
      reset = 1'b1;
      step(0, 0);
      reset = 1'b0;
      for (int k = 0; k < paths[p].len; k++) step(paths[p].tms_bits[k], 0);
      check({"path_", paths[p].name}, 256'(tap_state), 256'(paths[p].exp_state));
      for (int k = 0; k < 5; k++) step(1, 0);
      check({"tms5_", paths[p].name}, 256'(tap_state), 256'(4'hF));
    end

    step(0, 0);
    scan(1, 4, 256'(4'b1111), '0, tdo);
    check("ir_capture_pattern", tdo, 256'(4'b0001));
    scan(0, 5, 256'(5'b01101), '0, tdo);
    check("bypass_delay", tdo, 256'(5'b11010));

    scan(1, 4, 256'(4'b0001), '0, tdo);
    check("sample_ir_capture", tdo, 256'(4'b0001));
    scan(0, BSR, 256'(8'h3C), '0, tdo);
    check("sample_tdo_lsb8", 256'(tdo[7:0]), 256'(8'hA5));
    check("sample_tdo_full", 256'(tdo[BSR-1:0]), 256'(cap));
    check("preload_update", 256'(bsr_update_out), 256'(8'h3C));
    check("sample_modes", 256'({extest_mode, intest_mode, user_select}), 256'(0));

    scan(1, 4, 256'(4'b0000), '0, tdo);
    check("extest_mode", 256'({extest_mode, intest_mode, user_select}), 256'(3'b100));
    check("bsr_hold_ir", 256'(bsr_update_out), 256'(8'h3C));

    scan(1, 4, 256'(4'b0011), '0, tdo);
    check("intest_mode", 256'({extest_mode, intest_mode, user_select}), 256'(3'b010));

    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    reset = 1'b1;
    step(0, 1);
    reset = 1'b0;
    check("mid_shift_reset_state", 256'(tap_state), 256'(4'hF));
    check("mid_shift_reset_bsr",   256'(bsr_update_out), 256'(0));
    check("mid_shift_reset_modes", 256'({extest_mode, intest_mode, jif.TDO_en}), 256'(0));
    step(0, 0);
    scan(0, 32, '0, '0, tdo);
    check("idcode_after_reset", tdo, 256'(32'h1234_5003));

    reset = 1'b1;
    step(1, 0);
    reset = 1'b0;
    check("reset_beats_tms", 256'(tap_state), 256'(4'hF));
    step(0, 0);

    scan(1, 4, 256'(4'b0111), '0, tdo);
    check("undef_modes", 256'({extest_mode, intest_mode, user_select}), 256'(0));
    scan(0, 3, 256'(3'b011), '0, tdo);
    check("undef_bypass", tdo, 256'(3'b110));

    scan(1, 4, 256'(4'b0100), '0, tdo);
    check("user_select", 256'({extest_mode, intest_mode, user_select}), 256'(3'b001));
    cnt_cap   = 0;
    cnt_shift = 0;
    cnt_upd   = 0;
    mon_en    = 1'b1;
    scan(0, 5, '0, 256'(5'b10110), tdo);
    mon_en    = 1'b0;
    check("user_tdo_mirror", tdo, 256'(5'b10110));
    check("user_capture_cnt", 256'(cnt_cap), 256'(1));
    check("user_shift_cnt",   256'(cnt_shift), 256'(5));
    check("user_update_cnt",  256'(cnt_upd), 256'(1));

    for (int k = 0; k < 5; k++) step(1, 0);
    check("tlr_via_tms", 256'(tap_state), 256'(4'hF));
    check("tlr_clears_user", 256'(user_select), 256'(0));
    step(0, 0);
    scan(0, 32, '0, '0, tdo);
    check("idcode_after_tlr", tdo, 256'(32'h1234_5003));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
